// File: rtl/bin_to_hex_display.sv
// bin_to_hex_display: binary count to decimal seven-segment digits.
// Sequential double-dabble conversion, then active-low glyph registers.
//
// Ports:
//   clk       system clock
//   reset     asynchronous, active-high reset
//   in_value  binary value to display (WIDTH bits)
//   in_valid  in_value is valid; accepted only while in_ready is high
//   in_ready  high while idle and able to accept a value
//   seg       active-low segments, digit i at [7i+6:7i], bit 0 = a, bit 6 = g
//   bcd       registered BCD result, digit i at [4i+3:4i]
//   done      one-cycle pulse in the cycle seg/bcd take a new value
module bin_to_hex_display #(
    parameter int WIDTH         = 8,
    parameter int DIGITS        = 3,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      in_value,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [7*DIGITS-1:0]   seg,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    localparam logic [6:0] GLYPH_ZERO  = 7'b1000000;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    // The decimal field must be able to hold the largest input value.
    localparam longint MAX_IN  = (longint'(1) << WIDTH) - 1;
    localparam longint DEC_CAP = longint'(10) ** DIGITS;

    if (DEC_CAP <= MAX_IN) begin : g_bad_params
        $error("bin_to_hex_display: DIGITS too small for WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        UPDATE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   shreg;
    logic [BW-1:0]      work;
    logic [BW-1:0]      work_adj;
    logic [CW-1:0]      cnt;
    logic [7*DIGITS-1:0] seg_enc;
    logic [7*DIGITS-1:0] seg_rst;

    // Active-low gfedcba glyphs; non-decimal codes show blank.
    function automatic logic [6:0] enc7(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

    // Add-3 correction on every nibble before the shift, all in parallel.
    always_comb begin
        work_adj = work;
        for (int i = 0; i < DIGITS; i++) begin
            if (work[4*i +: 4] >= 4'd5)
                work_adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
        end
    end

    // Walk from the most significant digit down, tracking whether every
    // digit seen so far is zero; such digits (except units) go blank.
    always_comb begin
        logic upper_zero;
        seg_enc    = '0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (work[4*i +: 4] == 4'd0);
            if (BLANK_LEADING && (i != 0) && upper_zero)
                seg_enc[7*i +: 7] = GLYPH_BLANK;
            else
                seg_enc[7*i +: 7] = enc7(work[4*i +: 4]);
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_rst
        if (g == 0 || !BLANK_LEADING) begin : g_zero
            assign seg_rst[7*g +: 7] = GLYPH_ZERO;
        end else begin : g_blank
            assign seg_rst[7*g +: 7] = GLYPH_BLANK;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            done     <= 1'b0;
            bcd      <= '0;
            seg      <= seg_rst;
            shreg    <= '0;
            work     <= '0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg    <= in_value;
                        work     <= '0;
                        cnt      <= CW'(WIDTH);
                        in_ready <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    // {work, shreg} <<= 1 with the corrected nibbles.
                    work  <= {work_adj[BW-2:0], shreg[WIDTH-1]};
                    shreg <= {shreg[WIDTH-2:0], 1'b0};
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= UPDATE;
                end
                UPDATE: begin
                    bcd      <= work;
                    seg      <= seg_enc;
                    done     <= 1'b1;
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
